// File: rtl/axi_lite_regfile_pkg.sv
// axi_lite_regfile_pkg: shared response codes, channel FSM states and address-geometry helpers
package axi_lite_regfile_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int idx_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// axi_lite_addr_decode: splits a byte address into word index, out-of-range and read-only flags
module axi_lite_addr_decode #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ADDR_LSB       = 2,
    parameter int IDX_W          = 4,
    parameter int NUM_RW         = 12
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    output logic [IDX_W-1:0]          idx,
    output logic                      out_of_range,
    output logic                      is_ro
);

    logic unused;

    assign idx          = addr[ADDR_LSB +: IDX_W];
    assign out_of_range = |(addr >> (ADDR_LSB + IDX_W));
    assign is_ro        = 32'(idx) >= 32'(NUM_RW);
    assign unused       = &{1'b0, addr[ADDR_LSB-1:0]};

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// axi_lite_regfile_slave: AXI4-Lite register file with byte strobes, RO status words and per-register write pulses
module axi_lite_regfile_slave
    import axi_lite_regfile_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS       = 16,
    parameter int NUM_RO_REGS    = 4
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]  reg_out,
    output logic [NUM_REGS-1:0]                 wr_pulse,
    input  logic [NUM_RO_REGS*AXI_DATA_WIDTH-1:0] status_in
);

    localparam int ADDR_LSB  = addr_lsb(AXI_DATA_WIDTH);
    localparam int IDX_W     = idx_w(NUM_REGS);
    localparam int NUM_BYTES = AXI_DATA_WIDTH / 8;
    localparam int NUM_RW    = NUM_REGS - NUM_RO_REGS;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic                      aw_held, w_held, aw_held_nxt, w_held_nxt;
    logic                      awready, wready, arready;
    logic                      aw_hs, w_hs, ar_hs, b_hs, commit, wr_ok;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_eff;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_eff;
    logic [NUM_BYTES-1:0]      wstrb_q, wstrb_eff;
    logic [IDX_W-1:0]          aw_idx, ar_idx;
    logic                      aw_oor, aw_ro, ar_oor, ar_ro;
    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [AXI_DATA_WIDTH-1:0] rd_word [NUM_REGS];
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [NUM_REGS-1:0]       pulse;
    resp_t                     bresp, rresp;
    logic                      unused;

    assign aw_hs = S_AXI_AWVALID && awready;
    assign w_hs  = S_AXI_WVALID && wready;
    assign ar_hs = S_AXI_ARVALID && arready;
    assign b_hs  = S_AXI_BVALID && S_AXI_BREADY;

    // A half arriving in the commit cycle is used straight from the bus, so latency stays one cycle
    assign awaddr_eff = aw_held ? awaddr_q : S_AXI_AWADDR;
    assign wdata_eff  = w_held ? wdata_q : S_AXI_WDATA;
    assign wstrb_eff  = w_held ? wstrb_q : S_AXI_WSTRB;

    assign commit      = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_ok       = !aw_oor && !aw_ro;
    assign aw_held_nxt = !b_hs && (aw_held || aw_hs);
    assign w_held_nxt  = !b_hs && (w_held || w_hs);

    axi_lite_addr_decode #(
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
        .ADDR_LSB      (ADDR_LSB),
        .IDX_W         (IDX_W),
        .NUM_RW        (NUM_RW)
    ) u_aw_dec (
        .addr        (awaddr_eff),
        .idx         (aw_idx),
        .out_of_range(aw_oor),
        .is_ro       (aw_ro)
    );

    axi_lite_addr_decode #(
        .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
        .ADDR_LSB      (ADDR_LSB),
        .IDX_W         (IDX_W),
        .NUM_RW        (NUM_RW)
    ) u_ar_dec (
        .addr        (S_AXI_ARADDR),
        .idx         (ar_idx),
        .out_of_range(ar_oor),
        .is_ro       (ar_ro)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        assign reg_out[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[i];
        if (i < NUM_RW) begin : g_rw
            assign rd_word[i] = regs[i];
        end else begin : g_ro
            assign rd_word[i] = status_in[(i-NUM_RW)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end
    end

    // Write FSM next state: commit once both halves are available, then hold B until accepted
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_IDLE:  wr_state_nxt = commit ? WR_COMMIT : WR_IDLE;
            WR_COMMIT,
            WR_RESP:  wr_state_nxt = S_AXI_BREADY ? WR_IDLE : WR_RESP;
            default:  wr_state_nxt = WR_IDLE;
        endcase
    end

    // Read FSM next state: capture on AR handshake, hold R until accepted
    always_comb begin
        rd_state_nxt = rd_state;
        if (rd_state == RD_IDLE)
            rd_state_nxt = ar_hs ? RD_DATA : RD_IDLE;
        else
            rd_state_nxt = S_AXI_RREADY ? RD_IDLE : RD_DATA;
    end

    // Channel state and registered ready flags; readies stay low through reset
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            arready  <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            aw_held  <= aw_held_nxt;
            w_held   <= w_held_nxt;
            awready  <= !aw_held_nxt;
            wready   <= !w_held_nxt;
            arready  <= (rd_state_nxt == RD_IDLE);
        end
    end

    // Holding registers for independently accepted AW and W beats
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_hs)
                awaddr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // Register file: byte-lane merge on a legal commit; RO slots are never written and stay zero
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (commit && wr_ok) begin
            for (int b = 0; b < NUM_BYTES; b++)
                if (wstrb_eff[b])
                    regs[aw_idx][8*b +: 8] <= wdata_eff[8*b +: 8];
        end
    end

    // Write response code and the one-cycle write strobe, both produced at the commit edge
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bresp <= OKAY;
            pulse <= '0;
        end else begin
            pulse <= (commit && wr_ok) ? {{(NUM_REGS-1){1'b0}}, 1'b1} << aw_idx : '0;
            if (commit)
                bresp <= wr_ok ? OKAY : SLVERR;
        end
    end

    // Read capture: samples the register or status word at the AR handshake edge
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rdata <= '0;
            rresp <= OKAY;
        end else if (ar_hs) begin
            rdata <= ar_oor ? '0 : rd_word[ar_idx];
            rresp <= ar_oor ? SLVERR : OKAY;
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = (wr_state != WR_IDLE);
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = (rd_state == RD_DATA);
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = rresp;
    assign wr_pulse      = pulse;
    assign unused        = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, ar_ro};

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// tb_axi_lite_regfile_slave: directed scoreboard bench for the AXI4-Lite register file
module tb_axi_lite_regfile_slave;
    import axi_lite_regfile_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [31:0]  S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
    logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
    logic [3:0]   S_AXI_WSTRB;
    logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
    logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic         S_AXI_RVALID, S_AXI_RREADY;
    logic [511:0] reg_out;
    logic [15:0]  wr_pulse;
    logic [127:0] status_in;

    int errors = 0;
    int checks = 0;
    int pulse_cnt [16] = '{default: 0};
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    always #5 clk = ~clk;

    axi_lite_regfile_slave dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARPROT (S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .reg_out      (reg_out),
        .wr_pulse     (wr_pulse),
        .status_in    (status_in)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // B monitor: every accepted write response is matched against the scoreboard
    always @(negedge clk) begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
            if (bq.size() == 0) fail("b_unexpected");
            else chk("bresp", S_AXI_BRESP, bq.pop_front());
        end
    end

    // R monitor: every accepted read beat is matched against the scoreboard
    always @(negedge clk) begin
        if (S_AXI_RVALID && S_AXI_RREADY) begin
            logic [33:0] e;
            if (rq.size() == 0) fail("r_unexpected");
            else begin
                e = rq.pop_front();
                chk("rdata", S_AXI_RDATA, e[33:2]);
                chk("rresp", S_AXI_RRESP, e[1:0]);
            end
        end
    end

    // Write-pulse counter and one-hot guard
    always @(negedge clk) begin
        if ($countones(wr_pulse) > 1) fail("wr_pulse_onehot");
        for (int i = 0; i < 16; i++)
            if (wr_pulse[i]) pulse_cnt[i]++;
    end

    task automatic send_aw(input logic [31:0] a, input int d);
        int n;
        repeat (d) begin @(posedge clk); #1; end
        S_AXI_AWADDR  = a;
        S_AXI_AWVALID = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (S_AXI_AWREADY) break;
        end
        if (n == 50) fail("aw_timeout");
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] dt, input logic [3:0] s, input int d);
        int n;
        repeat (d) begin @(posedge clk); #1; end
        S_AXI_WDATA  = dt;
        S_AXI_WSTRB  = s;
        S_AXI_WVALID = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (S_AXI_WREADY) break;
        end
        if (n == 50) fail("w_timeout");
        @(posedge clk); #1;
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (S_AXI_ARREADY) break;
        end
        if (n == 50) fail("ar_timeout");
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_b();
        for (int i = 0; i < 40 && bq.size() != 0; i++) @(negedge clk);
        if (bq.size() != 0) begin fail("b_timeout"); bq.delete(); end
    endtask

    task automatic wait_r();
        for (int i = 0; i < 40 && rq.size() != 0; i++) @(negedge clk);
        if (rq.size() != 0) begin fail("r_timeout"); rq.delete(); end
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] dt, input logic [3:0] s,
                         input logic [1:0] er, input int aw_d, input int w_d);
        logic [15:0] ep;
        ep = (er == OKAY) ? (16'h1 << a[5:2]) : 16'h0;
        bq.push_back(er);
        @(posedge clk); #1;
        fork
            send_aw(a, aw_d);
            send_w(dt, s, w_d);
        join
        chk("bvalid_latency", S_AXI_BVALID, 1'b1);
        chk("wr_pulse", wr_pulse, ep);
        wait_b();
    endtask

    task automatic read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        rq.push_back({ed, er});
        @(posedge clk); #1;
        send_ar(a);
        chk("rvalid_latency", S_AXI_RVALID, 1'b1);
        wait_r();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] snap;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        status_in = {32'hCAFE0001, 32'h33333333, 32'h22222222, 32'h11111111};
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", S_AXI_AWREADY, 1'b0);
        chk("rst_wready", S_AXI_WREADY, 1'b0);
        chk("rst_arready", S_AXI_ARREADY, 1'b0);
        chk("rst_bvalid", S_AXI_BVALID, 1'b0);
        chk("rst_rvalid", S_AXI_RVALID, 1'b0);
        chk("rst_wr_pulse", wr_pulse, 16'h0);
        chk("rst_reg_out", reg_out, 512'h0);
        rst_n = 1'b1;
        #1;
        chk("awready_before_edge", S_AXI_AWREADY, 1'b0);
        @(posedge clk); #1;
        chk("awready_after_edge", S_AXI_AWREADY, 1'b1);
        chk("wready_after_edge", S_AXI_WREADY, 1'b1);
        chk("arready_after_edge", S_AXI_ARREADY, 1'b1);

        write(32'h0, 32'hDEADBEEF, 4'hF, OKAY, 0, 0);
        write(32'h4, 32'hBAADF00D, 4'hF, OKAY, 0, 0);
        write(32'h8, 32'hFEEDFACE, 4'hF, OKAY, 0, 0);
        write(32'hC, 32'h0BADC0DE, 4'hF, OKAY, 0, 0);
        read(32'h0, 32'hDEADBEEF, OKAY);
        read(32'h4, 32'hBAADF00D, OKAY);
        read(32'h8, 32'hFEEDFACE, OKAY);
        read(32'hC, 32'h0BADC0DE, OKAY);
        for (int i = 0; i < 4; i++) chk($sformatf("pulse_cnt%0d", i), pulse_cnt[i], 1);
        chk("reg_out1", reg_out[63:32], 32'hBAADF00D);
        chk("reg_out3", reg_out[127:96], 32'h0BADC0DE);

        write(32'h10, 32'hFFFFFFFF, 4'hF, OKAY, 0, 0);
        write(32'h10, 32'h12345678, 4'b0101, OKAY, 0, 0);
        read(32'h10, 32'hFF34FF78, OKAY);
        chk("reg_out4_strobe", reg_out[159:128], 32'hFF34FF78);

        write(32'h18, 32'hA5A5A5A5, 4'hF, OKAY, 3, 0);
        write(32'h1C, 32'h5A5A5A5A, 4'hF, OKAY, 0, 3);
        chk("pulse_cnt6_single", pulse_cnt[6], 1);
        chk("pulse_cnt7_single", pulse_cnt[7], 1);
        read(32'h18, 32'hA5A5A5A5, OKAY);
        read(32'h1C, 32'h5A5A5A5A, OKAY);

        write(32'h20, 32'hFFFFFFFF, 4'h0, OKAY, 0, 0);
        chk("pulse_cnt8_nostrobe", pulse_cnt[8], 1);
        read(32'h20, 32'h0, OKAY);

        snap = reg_out;
        write(32'h3C, 32'h11112222, 4'hF, SLVERR, 0, 0);
        write(32'h40, 32'h33334444, 4'hF, SLVERR, 0, 0);
        chk("reg_out_unchanged", reg_out, snap);
        chk("pulse_cnt15_ro", pulse_cnt[15], 0);
        read(32'h40, 32'h0, SLVERR);
        read(32'h3C, 32'hCAFE0001, OKAY);
        read(32'h30, 32'h11111111, OKAY);

        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;
        rq.push_back({32'hDEADBEEF, OKAY});
        send_ar(32'h0);
        write(32'h24, 32'h600DF00D, 4'hF, OKAY, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_rdata", S_AXI_RDATA, 32'hDEADBEEF);
            chk("stall_rvalid", S_AXI_RVALID, 1'b1);
            chk("stall_arready", S_AXI_ARREADY, 1'b0);
        end
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b1;
        wait_r();
        @(negedge clk);
        chk("arready_reassert", S_AXI_ARREADY, 1'b1);
        read(32'h24, 32'h600DF00D, OKAY);

        @(posedge clk); #1;
        send_aw(32'h28, 0);
        chk("aw_held_awready", S_AXI_AWREADY, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_awready", S_AXI_AWREADY, 1'b0);
        chk("abort_wready", S_AXI_WREADY, 1'b0);
        chk("abort_arready", S_AXI_ARREADY, 1'b0);
        chk("abort_bvalid", S_AXI_BVALID, 1'b0);
        chk("abort_rdata", S_AXI_RDATA, 32'h0);
        chk("abort_reg_out", reg_out, 512'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_no_commit", pulse_cnt[10], 0);
        write(32'h28, 32'h0BADCAFE, 4'hF, OKAY, 0, 0);
        chk("pulse_cnt10_after_reset", pulse_cnt[10], 1);
        read(32'h28, 32'h0BADCAFE, OKAY);
        read(32'h0, 32'h0, OKAY);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
